// File: rtl/alu_cmp_stage.sv
`default_nettype none
// ============================================================================
// alu_cmp_stage : flag/compare stage behind the DSP adder, 2-entry skid output
// Rev 1.0
// ============================================================================
module alu_cmp_stage #(
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [32:0]      in_sum,
  input  logic             in_a_msb,
  input  logic             in_b_msb,
  input  logic             in_sub,
  input  logic [2:0]       in_op,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_sum,
  output logic             out_zero,
  output logic             out_neg,
  output logic             out_carry,
  output logic             out_ovf,
  output logic             out_taken,
  output logic [TAG_W-1:0] out_tag
);

  localparam logic [2:0] c_OP_BEQ  = 3'b000;
  localparam logic [2:0] c_OP_BNE  = 3'b001;
  localparam logic [2:0] c_OP_SLT  = 3'b010;
  localparam logic [2:0] c_OP_SLTU = 3'b011;
  localparam logic [2:0] c_OP_BLT  = 3'b100;
  localparam logic [2:0] c_OP_BGE  = 3'b101;
  localparam logic [2:0] c_OP_BLTU = 3'b110;
  localparam logic [2:0] c_OP_BGEU = 3'b111;

  typedef struct packed {
    logic [31:0]      sum;
    logic             zero;
    logic             neg;
    logic             carry;
    logic             ovf;
    logic             taken;
    logic [TAG_W-1:0] tag;
  } entry_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t r_state;
  entry_t r_main;
  entry_t r_skid;
  logic   r_in_ready;
  logic   r_out_valid;

  logic   w_zero;
  logic   w_neg;
  logic   w_carry;
  logic   w_ovf;
  logic   w_lt;
  logic   w_ltu;
  logic   w_taken;
  logic   w_accept;
  logic   w_emit;
  entry_t w_entry;

  assign w_zero  = (in_sum[31:0] == 32'd0);
  assign w_neg   = in_sum[31];
  assign w_carry = in_sum[32];
  // For subtraction the effective second operand sign is inverted.
  assign w_ovf   = (in_sub ? (in_a_msb ^ in_b_msb) : ~(in_a_msb ^ in_b_msb))
                 & (in_sum[31] ^ in_a_msb);
  assign w_lt    = w_neg ^ w_ovf;
  assign w_ltu   = ~w_carry;

  always_comb begin
    w_taken = 1'b0;
    case (in_op)
      c_OP_BEQ:  w_taken = w_zero;
      c_OP_BNE:  w_taken = ~w_zero;
      c_OP_SLT:  w_taken = w_lt;
      c_OP_SLTU: w_taken = w_ltu;
      c_OP_BLT:  w_taken = w_lt;
      c_OP_BGE:  w_taken = ~w_lt;
      c_OP_BLTU: w_taken = w_ltu;
      c_OP_BGEU: w_taken = ~w_ltu;
      default:   w_taken = 1'b0;
    endcase
  end

  always_comb begin
    w_entry.sum   = in_sum[31:0];
    w_entry.zero  = w_zero;
    w_entry.neg   = w_neg;
    w_entry.carry = w_carry;
    w_entry.ovf   = w_ovf;
    w_entry.taken = w_taken;
    w_entry.tag   = in_tag;
  end

  assign w_accept = in_valid & r_in_ready;
  assign w_emit   = r_out_valid & out_ready;

  // Ready/valid are registered alongside the state so in_ready never sees out_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_EMPTY;
      r_main      <= '0;
      r_skid      <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            r_main      <= w_entry;
            r_out_valid <= 1'b1;
            r_state     <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (w_accept && w_emit) begin
            r_main <= w_entry;
          end else if (w_accept) begin
            r_skid     <= w_entry;
            r_in_ready <= 1'b0;
            r_state    <= ST_FULL;
          end else if (w_emit) begin
            r_out_valid <= 1'b0;
            r_state     <= ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (w_emit) begin
            r_main     <= r_skid;
            r_in_ready <= 1'b1;
            r_state    <= ST_ONE;
          end
        end
        default: begin
          r_state     <= ST_EMPTY;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_sum   = r_main.sum;
  assign out_zero  = r_main.zero;
  assign out_neg   = r_main.neg;
  assign out_carry = r_main.carry;
  assign out_ovf   = r_main.ovf;
  assign out_taken = r_main.taken;
  assign out_tag   = r_main.tag;

endmodule
`default_nettype wire

// File: tb/tb_alu_cmp_stage.sv
`default_nettype none
// ============================================================================
// tb_alu_cmp_stage : randomized + directed bench with an operand-level model
// Rev 1.0
// ============================================================================
module tb_alu_cmp_stage;
  localparam int TAG_W = 5;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [32:0]      in_sum;
  logic             in_a_msb;
  logic             in_b_msb;
  logic             in_sub;
  logic [2:0]       in_op;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_sum;
  logic             out_zero;
  logic             out_neg;
  logic             out_carry;
  logic             out_ovf;
  logic             out_taken;
  logic [TAG_W-1:0] out_tag;

  always #5 clk = ~clk;

  alu_cmp_stage #(.TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_sum(in_sum),
    .in_a_msb(in_a_msb), .in_b_msb(in_b_msb), .in_sub(in_sub),
    .in_op(in_op), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_zero(out_zero), .out_neg(out_neg), .out_carry(out_carry),
    .out_ovf(out_ovf), .out_taken(out_taken), .out_tag(out_tag)
  );

  typedef struct packed {
    logic [31:0]      a;
    logic [31:0]      b;
    logic             sub;
    logic [2:0]       op;
    logic [TAG_W-1:0] tag;
  } item_t;

  typedef struct packed {
    logic [31:0]      sum;
    logic             z, n, c, v, t;
    logic [TAG_W-1:0] tag;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  function automatic item_t mk(input logic [31:0] a, input logic [31:0] b,
                               input logic sub, input logic [2:0] op,
                               input logic [TAG_W-1:0] tag);
    item_t it;
    it.a = a; it.b = b; it.sub = sub; it.op = op; it.tag = tag;
    return it;
  endfunction

  function automatic item_t rnd_item();
    return mk($urandom, ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom,
              ($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
              TAG_W'($urandom_range(0, 31)));
  endfunction

  function automatic logic [32:0] adder(input item_t it);
    if (it.sub) return {1'b0, it.a} + {1'b0, ~it.b} + 33'd1;
    return {1'b0, it.a} + {1'b0, it.b};
  endfunction

  // Expected result from the operands themselves: true integer compare for subtraction.
  function automatic exp_t model(input item_t it);
    exp_t        e;
    logic [32:0] s;
    longint      sa, sb, r;
    logic        eq, lts, ltu;
    s  = adder(it);
    sa = longint'($signed(it.a));
    sb = longint'($signed(it.b));
    r  = it.sub ? (sa - sb) : (sa + sb);
    e.sum = s[31:0];
    e.z   = (s[31:0] == 32'd0);
    e.n   = s[31];
    e.c   = s[32];
    e.v   = (r > 64'sd2147483647) || (r < -64'sd2147483648);
    if (it.sub) begin
      eq = (it.a == it.b); lts = (sa < sb); ltu = (it.a < it.b);
    end else begin
      eq = e.z; lts = e.n ^ e.v; ltu = ~e.c;
    end
    case (it.op)
      3'd0:       e.t = eq;
      3'd1:       e.t = ~eq;
      3'd2, 3'd4: e.t = lts;
      3'd3, 3'd6: e.t = ltu;
      3'd5:       e.t = ~lts;
      default:    e.t = ~ltu;
    endcase
    e.tag = it.tag;
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, expv);
    end
  endtask

  task automatic chk_reset();
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_sum", 64'(out_sum), 64'd0);
    chk("rst_flags", 64'({out_zero, out_neg, out_carry, out_ovf, out_taken}), 64'd0);
    chk("rst_out_tag", 64'(out_tag), 64'd0);
  endtask

  // One clock: drive, check handshake + head entry against the model, advance.
  task automatic tick(input logic v, input item_t it, input logic ordy);
    logic [32:0] s;
    logic        acc, em;
    exp_t        h;
    s         = adder(it);
    in_valid  = v;
    in_sum    = s;
    in_a_msb  = it.a[31];
    in_b_msb  = it.b[31];
    in_sub    = it.sub;
    in_op     = it.op;
    in_tag    = it.tag;
    out_ready = ordy;
    #1;
    chk("in_ready", 64'(in_ready), 64'(q.size() < 2));
    chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
    acc = v && (q.size() < 2);
    em  = ordy && (q.size() != 0);
    if (em) begin
      h = q.pop_front();
      chk("out_sum", 64'(out_sum), 64'(h.sum));
      chk("flags_zncv", 64'({out_zero, out_neg, out_carry, out_ovf}), 64'({h.z, h.n, h.c, h.v}));
      chk("out_taken", 64'(out_taken), 64'(h.t));
      chk("out_tag", 64'(out_tag), 64'(h.tag));
    end
    if (acc) q.push_back(model(it));
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 4; i++) tick(1'b0, rnd_item(), 1'b1);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_sum = '0; in_a_msb = 1'b0; in_b_msb = 1'b0;
    in_sub = 1'b0; in_op = '0; in_tag = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // BEQ 5-5
    tick(1'b1, mk(32'd5, 32'd5, 1'b1, 3'b000, 5'd1), 1'b1);
    chk("beq_valid", 64'(out_valid), 64'd1);
    chk("beq_zcv", 64'({out_zero, out_carry, out_ovf}), 64'b110);
    chk("beq_taken", 64'(out_taken), 64'd1);

    // 1-2 for BLT/BLTU/SLTU/BGE
    tick(1'b1, mk(32'd1, 32'd2, 1'b1, 3'b100, 5'd2), 1'b1);
    chk("blt_1_2", 64'(out_taken), 64'd1);
    tick(1'b1, mk(32'd1, 32'd2, 1'b1, 3'b110, 5'd3), 1'b1);
    chk("bltu_1_2", 64'(out_taken), 64'd1);
    tick(1'b1, mk(32'd1, 32'd2, 1'b1, 3'b011, 5'd4), 1'b1);
    chk("sltu_1_2", 64'(out_taken), 64'd1);
    tick(1'b1, mk(32'd1, 32'd2, 1'b1, 3'b101, 5'd5), 1'b1);
    chk("bge_1_2", 64'(out_taken), 64'd0);
    chk("sum_1_2", 64'(out_sum), 64'hFFFF_FFFF);

    // 0x80000000 - 1: signed overflow
    tick(1'b1, mk(32'h8000_0000, 32'd1, 1'b1, 3'b100, 5'd6), 1'b1);
    chk("ovf_vn", 64'({out_ovf, out_neg}), 64'b10);
    chk("ovf_blt", 64'(out_taken), 64'd1);
    tick(1'b1, mk(32'h8000_0000, 32'd1, 1'b1, 3'b110, 5'd7), 1'b1);
    chk("ovf_bltu", 64'(out_taken), 64'd0);
    drain();

    // Backpressure: tags 1,2,3 with out_ready low, tag 3 held upstream
    tick(1'b1, mk($urandom, $urandom, 1'b1, 3'd0, 5'd1), 1'b0);
    tick(1'b1, mk($urandom, $urandom, 1'b1, 3'd1, 5'd2), 1'b0);
    chk("bp_ready_low", 64'(in_ready), 64'd0);
    tick(1'b1, mk(32'd9, 32'd3, 1'b1, 3'd2, 5'd3), 1'b0);
    chk("bp_hold_tag", 64'(out_tag), 64'd1);
    tick(1'b1, mk(32'd9, 32'd3, 1'b1, 3'd2, 5'd3), 1'b1);
    chk("bp_second_tag", 64'(out_tag), 64'd2);
    tick(1'b1, mk(32'd9, 32'd3, 1'b1, 3'd2, 5'd3), 1'b1);
    chk("bp_third_tag", 64'(out_tag), 64'd3);
    drain();

    // Streaming, 16 back-to-back
    for (int i = 0; i < 16; i++) tick(1'b1, rnd_item(), 1'b1);
    drain();

    // Random traffic
    for (int i = 0; i < 400; i++)
      tick(($urandom_range(0, 3) != 0), rnd_item(), ($urandom_range(0, 2) != 0));
    drain();

    // Asynchronous reset while FULL
    tick(1'b1, rnd_item(), 1'b0);
    tick(1'b1, rnd_item(), 1'b0);
    chk("full_before_rst", 64'({in_ready, out_valid}), 64'b01);
    in_valid = 1'b0; out_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk_reset();
    q.delete();
    @(posedge clk);
    #2 rst_n = 1'b1;
    tick(1'b1, mk(32'd7, 32'd7, 1'b1, 3'b001, 5'd9), 1'b1);
    chk("post_rst_bne", 64'(out_taken), 64'd0);
    chk("post_rst_tag", 64'(out_tag), 64'd9);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_cmp_stage.md
# alu_cmp_stage

Registered flag and compare stage directly downstream of the DSP adder (`ALUadrDSP`). It captures the adder's 33-bit result with the operand sign bits and derives the zero, negative, carry and overflow flags. From those flags it resolves the RV32I branch condition or the SLT/SLTU result. It presents everything through a valid/ready interface backed by a 2-entry skid buffer, so that `in_ready` is never combinationally dependent on `out_ready`.

## Interface
- TAG_W, 5: width of the pass-through tag (destination register index).
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset; asynchronous, active-low.
- in_valid  in  1  upstream holds a valid adder result.
- in_ready  out  1  stage can accept; registered.
- in_sum  in  33  adder output: bit 32 is the carry-out, bits 31:0 are the sum.
- in_a_msb  in  1  bit 31 of the adder's input1.
- in_b_msb  in  1  bit 31 of the adder's input2, before inversion.
- in_sub  in  1  adder ctl; 1 means the adder computed input1 + ~input2 + 1.
- in_op  in  3  RV32I funct3: 000 BEQ, 001 BNE, 010 SLT, 011 SLTU, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU.
- in_tag  in  TAG_W  opaque; passed through unchanged.
- out_valid  out  1  output entry valid.
- out_ready  in  1  downstream accepts.
- out_sum  out  32  in_sum[31:0] of the entry.
- out_zero, out_neg, out_carry, out_ovf  out  1 each  flags Z, N, C, V.
- out_taken  out  1  condition result: branch taken, or the SLT/SLTU bit.
- out_tag  out  TAG_W  tag of the entry.

## Operation
- Flags are computed on input, before capture:
  - Z = (in_sum[31:0] == 0).
  - N = in_sum[31].
  - C = in_sum[32].
  - With in_sub=1: V = (in_a_msb != in_b_msb) & (in_sum[31] != in_a_msb).
  - With in_sub=0: V = (in_a_msb == in_b_msb) & (in_sum[31] != in_a_msb).
- Comparison terms: signed less-than lt = N ^ V; unsigned less-than ltu = ~C (carry set means no borrow).
- out_taken by in_op: 000 Z; 001 ~Z; 010 lt; 011 ltu; 100 lt; 101 ~lt; 110 ltu; 111 ~ltu.
- out_taken is evaluated with the same formulas when in_sub=0. The result is defined but meaningless; upstream asserts in_sub for every compare.
- Storage is two entries, MAIN (drives the outputs) and SKID. States:
  - EMPTY: in_ready=1, out_valid=0.
  - ONE: MAIN valid, in_ready=1, out_valid=1.
  - FULL: MAIN and SKID valid, in_ready=0, out_valid=1.
- Transfers: accept = in_valid & in_ready; emit = out_valid & out_ready.
- EMPTY:
  - accept: load MAIN, go to ONE.
- ONE:
  - accept & emit: load MAIN, stay in ONE.
  - accept only: load SKID, go to FULL.
  - emit only: go to EMPTY.
- FULL:
  - emit: SKID moves to MAIN, go to ONE.
  - no emit: hold.
- in_valid is ignored while in_ready=0. No entry is ever dropped or duplicated.
- Entries leave in strict FIFO order.
- Reset (any cycle, including mid-transfer): state EMPTY and both entries invalidated.

## Timing
- Latency: 1 cycle. An entry accepted at edge k is visible on the outputs after edge k.
- Throughput: 1 entry per cycle while out_ready=1.
- in_ready is a register output. It falls one cycle after the second unconsumed accept.
- Output payload is stable while out_valid=1 and out_ready=0.
- Reset values:
  - in_ready=1, out_valid=0.
  - out_sum=0, out_zero=0, out_neg=0, out_carry=0, out_ovf=0, out_taken=0.
  - out_tag=0.
- Reset asserts immediately; sampling resumes on the first clk edge after rst_n rises.

## Test plan
- BEQ, 5-5: in_sum=0x1_00000000, in_sub=1, in_op=000, out_ready=1. Next cycle: out_valid=1, Z=1, C=1, V=0, out_taken=1.
- 1-2 with BLT/BLTU/SLTU: in_sum=0x0_FFFFFFFF, msbs 0/0, in_sub=1. out_taken=1 for op 100, 110 and 011; 0 for op 101.
- Signed overflow, 0x80000000-1: in_sum=0x1_7FFFFFFF, a_msb=1, b_msb=0, in_sub=1. V=1, N=0, lt=1: op 100 gives out_taken=1; op 110 gives out_taken=0.
- Backpressure:
  - Stimulus: out_ready=0; send tags 1, 2, 3 on consecutive cycles.
  - Required: tags 1 and 2 accepted; in_ready=0 from the cycle after tag 2; tag 3 held upstream.
  - Then raise out_ready: tags 1, 2, 3 emerge in order with no loss.
- Streaming: 16 back-to-back entries with out_ready=1 throughout. in_ready stays 1, one output per cycle, payloads match.
- Reset mid-operation: in FULL, pulse rst_n low asynchronously between edges. Outputs go to reset values immediately, then the next accept is handled from EMPTY.
